// File: rtl/cacheline_adapter_pkg.sv
// -----------------------------------------------------------------------------
// cacheline_adapter_pkg
// Shared cache definitions for the cache-line <-> memory-burst adapter:
//   LINE_W / BEAT_W / BEATS : line geometry (256-bit line, 64-bit beats, 4 beats)
//   ADDR_W / OFFSET_W       : address width and byte offset within a line
//   adapter_state_e         : adapter FSM states
//   align_line_addr()       : clears the in-line byte offset of an address
// -----------------------------------------------------------------------------
package cacheline_adapter_pkg;

  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int BEATS    = 4;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_BURST = 3'd1,
    RD_DONE  = 3'd2,
    WR_BURST = 3'd3,
    WR_DONE  = 3'd4
  } adapter_state_e;

  // Masking (rather than slicing) keeps every address bit referenced.
  function automatic logic [ADDR_W-1:0] align_line_addr(input logic [ADDR_W-1:0] addr);
    return addr & {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// -----------------------------------------------------------------------------
// cacheline_adapter
// Converts whole-line cache requests into BEATS-beat memory bursts.
//   Cache side : address_i, line_i, read_i, write_i  -> line_o, resp_o
//   Memory side: address_o, burst_o, read_o, write_o <- burst_i, resp_i
// A fill assembles incoming beats (beat 0 = line bits 63:0) straight into
// line_o; a write-back streams the latched line low beat first. resp_o pulses
// for one cycle in the DONE state, after which a new request is accepted
// immediately. write_i wins over read_i when both are raised together.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   address_i    : cache line address (byte address, offset ignored)
//   line_i       : write-back line, sampled when a write is accepted
//   read_i/write_i : cache request, held until resp_o
//   line_o       : assembled fill line
//   resp_o       : one-cycle line-done pulse
//   address_o    : aligned burst address, 0 when not bursting
//   burst_o/burst_i : write / read beat data
//   read_o/write_o  : burst request, held for the whole burst
//   resp_i       : per-beat acknowledge from memory
// -----------------------------------------------------------------------------
module cacheline_adapter #(
  parameter int BEATS = cacheline_adapter_pkg::BEATS
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [cacheline_adapter_pkg::ADDR_W-1:0] address_i,
  input  logic [cacheline_adapter_pkg::LINE_W-1:0] line_i,
  input  logic                                  read_i,
  input  logic                                  write_i,
  output logic [cacheline_adapter_pkg::LINE_W-1:0] line_o,
  output logic                                  resp_o,
  output logic [cacheline_adapter_pkg::ADDR_W-1:0] address_o,
  output logic [cacheline_adapter_pkg::BEAT_W-1:0] burst_o,
  input  logic [cacheline_adapter_pkg::BEAT_W-1:0] burst_i,
  output logic                                  read_o,
  output logic                                  write_o,
  input  logic                                  resp_i
);

  import cacheline_adapter_pkg::*;

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  adapter_state_e   state_r;
  logic [CNT_W-1:0] cnt_r;
  // Remaining (not yet presented) write-back beats, lowest beat in bits 63:0.
  logic [LINE_W-1:0] wline_r;
  logic              last_beat_s;

  // Flags the beat whose acknowledge completes the burst.
  always_comb begin
    last_beat_s = 1'b0;
    if (cnt_r == CNT_W'(BEATS - 1)) begin
      last_beat_s = 1'b1;
    end else begin
      last_beat_s = 1'b0;
    end
  end

  // Adapter FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      wline_r   <= '0;
      line_o    <= '0;
      resp_o    <= 1'b0;
      address_o <= '0;
      burst_o   <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          resp_o <= 1'b0;
          cnt_r  <= '0;
          if (write_i) begin
            state_r   <= WR_BURST;
            address_o <= align_line_addr(address_i);
            write_o   <= 1'b1;
            // First beat goes out now; the rest shift down one beat per ack.
            burst_o   <= line_i[BEAT_W-1:0];
            wline_r   <= line_i >> BEAT_W;
          end else if (read_i) begin
            state_r   <= RD_BURST;
            address_o <= align_line_addr(address_i);
            read_o    <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end

        RD_BURST: begin
          if (resp_i) begin
            line_o[int'(cnt_r)*BEAT_W +: BEAT_W] <= burst_i;
            if (last_beat_s) begin
              state_r   <= RD_DONE;
              cnt_r     <= '0;
              read_o    <= 1'b0;
              address_o <= '0;
              resp_o    <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end else begin
            state_r <= RD_BURST;
          end
        end

        WR_BURST: begin
          if (resp_i) begin
            if (last_beat_s) begin
              state_r   <= WR_DONE;
              cnt_r     <= '0;
              write_o   <= 1'b0;
              address_o <= '0;
              burst_o   <= '0;
              resp_o    <= 1'b1;
            end else begin
              cnt_r   <= cnt_r + CNT_W'(1);
              burst_o <= wline_r[BEAT_W-1:0];
              wline_r <= wline_r >> BEAT_W;
            end
          end else begin
            state_r <= WR_BURST;
          end
        end

        // resp_o was raised on entry; drop it and return to IDLE.
        RD_DONE, WR_DONE: begin
          resp_o  <= 1'b0;
          state_r <= IDLE;
        end

        default: begin
          state_r   <= IDLE;
          cnt_r     <= '0;
          wline_r   <= '0;
          resp_o    <= 1'b0;
          address_o <= '0;
          burst_o   <= '0;
          read_o    <= 1'b0;
          write_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cacheline_adapter.md
CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port address_i  input  32  cache line address, valid while read_i or write_i is high.
REQ-004 SHALL have port line_i  input  256  write-back line from cache, valid while write_i is high.
REQ-005 SHALL have port read_i / write_i  input  1 each  cache line request, held high until resp_o.
REQ-006 SHALL have port line_o  output  256  assembled fill line.
REQ-007 SHALL have port resp_o  output  1  one-cycle line-done pulse to cache.
REQ-008 SHALL have port address_o  output  32  burst address to memory.
REQ-009 SHALL have port burst_o  output  64  write beat data.
REQ-010 SHALL have port burst_i  input  64  read beat data.
REQ-011 SHALL have port read_o / write_o  output  1 each  burst request, held high for the whole burst.
REQ-012 SHALL have port resp_i  input  1  per-beat acknowledge from memory.
REQ-013 SHALL have parameter BEATS, default 4, meaning 64-bit beats per 256-bit line.

Function
REQ-014 SHALL implement states IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
REQ-015 In IDLE with write_i=1, SHALL latch line_i and {address_i[31:5],5'b0} and go to WR_BURST; write_i has priority when read_i=1 in the same cycle.
REQ-016 In IDLE with read_i=1 and write_i=0, SHALL latch the aligned address and go to RD_BURST.
REQ-017 In RD_BURST, SHALL hold read_o=1 and, on each cycle with resp_i=1, store burst_i into beat[count] (beat 0 = bits 63:0) and increment a 2-bit beat counter.
REQ-018 SHALL leave RD_BURST for RD_DONE on the cycle the final beat (count=BEATS-1) is accepted; gaps with resp_i=0 SHALL stall without losing data.
REQ-019 In WR_BURST, SHALL hold write_o=1, drive burst_o=beat[count] of the latched line, and advance count on each cycle with resp_i=1.
REQ-020 SHALL leave WR_BURST for WR_DONE when the final beat is acknowledged.
REQ-021 In RD_DONE and WR_DONE, SHALL assert resp_o=1 for exactly one cycle, then return to IDLE.
REQ-022 line_o SHALL equal the full assembled line while resp_o=1 and SHALL remain stable until the next read's first beat is accepted.
REQ-023 address_o SHALL hold the latched aligned address throughout each burst and SHALL be 0 in IDLE.
REQ-024 read_o and write_o SHALL never be high in the same cycle.
REQ-025 resp_i SHALL be ignored in IDLE and DONE states.
REQ-026 Request-accept to resp_o latency SHALL be (BEATS + 2) cycles with zero memory wait cycles.
REQ-027 A new request arriving the cycle after resp_o (write-back followed by fill) SHALL be accepted from IDLE with no extra idle cycle.

Reset
REQ-028 While rst_n=0, SHALL force the state to IDLE, the counter to 0, and resp_o, read_o, write_o, address_o, burst_o, and line_o to 0, asynchronously.
REQ-029 A reset during a burst SHALL abandon it with no resp_o; the cache reissues the request.

Structure
REQ-030 SHALL place the state enum, LINE_W=256, BEAT_W=64, and BEATS=4 in the shared cache package.
REQ-031 SHALL be a single module; no sub-module is warranted.

Verification
REQ-032 Read with zero-wait memory returning beats 64'h0..0, ..0001, ..0002, ..0003 at address 32'h0000_1234 -> address_o=32'h0000_1220; line_o={..3,..2,..1,..0}; resp_o pulses on cycle 6.
REQ-033 Write of line 256'hAAAA..._BBBB... at 32'h8000_0040 -> burst_o shows the four 64-bit slices low-first; write_o drops after the fourth resp_i; resp_o pulses once.
REQ-034 Read with resp_i idle 3 cycles between beats 1 and 2 -> the assembled line is identical to the zero-wait case; resp_o is delayed by 3 cycles.
REQ-035 Write followed by read issued the cycle after resp_o -> read_o rises on the next cycle; no beat from the write leaks into line_o.
REQ-036 rst_n pulled low after 2 read beats, then released and the read reissued -> no resp_o during the aborted burst; the fresh 4-beat fill completes correctly.
REQ-037 read_i=1 and write_i=1 simultaneously in IDLE -> write_o is asserted and read_o stays 0.
